corner_merge_rr: RTL

- Parametrised successor to the 4-lane corner-record drain stage.
- Accepts N lanes of 32-bit corner records, one per lane per cycle, from the nonmax stage.
- Buffers each lane in its own shallow FIFO and drains them with a work-conserving round-robin arbiter onto one 32-bit stream.
- Enforces a per-frame record cap, counts drops, and (optionally) appends an end-of-frame trailer word for the DMA/host side.

---
 rtl/corner_merge_rr_pkg.sv | 47 ++++
 rtl/corner_merge_rr_rr_arb.sv | 56 +++++
 rtl/corner_merge_rr.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/corner_merge_rr_pkg.sv
// ---------------------------------------------------------------------------
// corner_merge_rr_pkg
// Shared definitions for the corner-record merge stage:
//   - corner record field positions (col / row / score)
//   - end-of-frame trailer marker and trailer field offsets
//   - merge FSM state encoding
//   - small helpers (12-bit saturation, 16-bit popcount)
// ---------------------------------------------------------------------------
package corner_merge_rr_pkg;

    // Corner record layout: {3'b000, col[10:0], row[9:0], score[7:0]}
    localparam int REC_COL_MSB   = 28;
    localparam int REC_COL_LSB   = 18;
    localparam int REC_ROW_MSB   = 17;
    localparam int REC_ROW_LSB   = 8;
    localparam int REC_SCORE_MSB = 7;
    localparam int REC_SCORE_LSB = 0;

    // Trailer layout: {marker[31:29], cam[28], drops[27:16], emitted[15:0]}.
    // The marker value never occurs in a record because col stops at bit 28.
    localparam logic [2:0] TRAILER_MARK = 3'b111;
    localparam int TRL_MARK_LSB = 29;
    localparam int TRL_CAM_BIT  = 28;
    localparam int TRL_DROP_LSB = 16;
    localparam int TRL_QV_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FRAME   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_TRAILER = 2'd3
    } merge_state_t;

    function automatic logic [11:0] sat12(input logic [15:0] v);
        return (v > 16'h0FFF) ? 12'hFFF : v[11:0];
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/corner_merge_rr_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Work-conserving round-robin arbiter. The search starts at the lane after the
// last grant (held in ptr_reg, which resets to lane 0) and wraps around.
// Ports:
//   clk, srst    clock / synchronous active-high reset
//   req[N]       per-lane request (lane non-empty)
//   advance      move the pointer past the current grant (low = stalled)
//   grant[N]     one-hot grant
//   grant_idx    encoded grant index
//   grant_valid  some lane was granted
// ---------------------------------------------------------------------------
module rr_arb #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    // Holds (last_grant + 1) mod N, i.e. the first lane to look at.
    logic [IW-1:0] ptr_reg;

    // Walk offsets from far to near so the nearest requesting lane wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr_reg) + off) % N;
            if (req[idx]) begin
                grant_idx   = IW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign grant[gi] = grant_valid && (grant_idx == IW'(gi));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= '0;
        end else if (advance && grant_valid) begin
            ptr_reg <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/corner_merge_rr.sv
// ---------------------------------------------------------------------------
// corner_merge_rr
// Merges LANES lanes of 32-bit corner records onto one registered stream.
// Each lane has its own show-ahead FIFO (block RAM, registered read); a
// round-robin arbiter drains them at one word per cycle. A per-frame cap
// limits emitted records; overflowed or capped records are counted as drops.
//
// Optional feature (macro CORNER_TRAILER_EN): after the frame drains, one
// trailer word {3'b111, CAM_ADDR, drops[11:0] sat, emitted} is emitted and
// the counters clear in that cycle instead of at frame start.
//
// Ports:
//   c         clock
//   rst       synchronous active-high reset (flushes all FIFOs)
//   en        record write enable
//   fv        frame valid (aligned with the record stream)
//   d         lane i record at d[32*i +: 32]
//   dv        per-lane record valid
//   q, qv     output word and one-cycle valid strobe (registered)
//   qv_cnt    records emitted this frame
//   drop_cnt  records dropped this frame (saturating)
//   busy      any FIFO non-empty or FSM not IDLE
// ---------------------------------------------------------------------------
module corner_merge_rr
    import corner_merge_rr_pkg::*;
#(
    parameter logic CAM_ADDR = 1'b0,
    parameter int   LANES    = 4,
    parameter int   DEPTH    = 256,
    parameter int   MAX_QV   = 16383
) (
    input  logic                  c,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fv,
    input  logic [LANES*32-1:0]   d,
    input  logic [LANES-1:0]      dv,
    output logic [31:0]           q,
    output logic                  qv,
    output logic [15:0]           qv_cnt,
    output logic [15:0]           drop_cnt,
    output logic                  busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(LANES);

    logic [LANES-1:0]       lane_req;
    logic [LANES-1:0]       lane_drop;
    logic [LANES-1:0]       lane_busy;
    logic [LANES-1:0][31:0] lane_data;
    logic [LANES-1:0]       grant;
    logic [IW-1:0]          grant_idx;
    logic                   grant_valid;
    logic                   stall;
    logic                   pop;

    merge_state_t state_reg, state_next;

    // ---------------- lane FIFOs ----------------
    // A record written at edge n becomes readable only after edge n+1, when
    // the registered RAM read has caught it. wr_d_reg hides that newest entry
    // from the arbiter for one cycle.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [31:0]   mem_reg [DEPTH];
        logic [AW-1:0] wr_ptr_reg;
        logic [AW-1:0] rd_ptr_reg;
        logic [AW:0]   cnt_reg;
        logic          wr_d_reg;
        logic [31:0]   rd_data_reg;
        logic [AW-1:0] rd_addr;
        logic          full;
        logic          wr;
        logic          rd;

        assign full    = (cnt_reg == (AW+1)'(DEPTH));
        assign wr      = en & dv[gi] & ~full;
        assign rd      = pop & grant[gi];
        // Look one entry ahead when popping so the head stays show-ahead.
        assign rd_addr = rd ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

        always_ff @(posedge c) begin
            if (wr) begin
                mem_reg[wr_ptr_reg] <= d[32*gi +: 32];
            end
            rd_data_reg <= mem_reg[rd_addr];
        end

        always_ff @(posedge c) begin
            if (rst) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                cnt_reg    <= '0;
                wr_d_reg   <= 1'b0;
            end else begin
                if (wr) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (rd) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                cnt_reg  <= cnt_reg + (AW+1)'(wr) - (AW+1)'(rd);
                wr_d_reg <= wr;
            end
        end

        assign lane_req[gi]  = (cnt_reg != (AW+1)'(wr_d_reg));
        assign lane_drop[gi] = en & dv[gi] & full;
        assign lane_busy[gi] = (cnt_reg != '0);
        assign lane_data[gi] = rd_data_reg;
    end

    // ---------------- arbiter ----------------
    rr_arb #(.N(LANES)) u_arb (
        .clk         (c),
        .srst        (rst),
        .req         (lane_req),
        .advance     (~stall),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // The trailer cycle owns the output register, so nothing is popped then.
    assign stall = (state_reg == ST_TRAILER);
    assign pop   = grant_valid & ~stall;

    // ---------------- frame tracking / FSM ----------------
    logic fv_d_reg;
    logic frame_start;
    logic frame_end;
    logic all_idle;

    assign frame_start = fv & ~fv_d_reg;
    assign frame_end   = ~fv & fv_d_reg;
    assign all_idle    = ~|lane_busy;

    always_ff @(posedge c) begin
        if (rst) begin
            fv_d_reg  <= 1'b0;
            state_reg <= ST_IDLE;
        end else begin
            fv_d_reg  <= fv;
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (frame_start) state_next = ST_FRAME;
            end
`ifdef CORNER_TRAILER_EN
            ST_FRAME: begin
                if (frame_end) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A new frame cuts the drain short; whatever is still buffered
                // is counted against the new frame.
                if (frame_start || all_idle) state_next = ST_TRAILER;
            end
            ST_TRAILER: begin
                state_next = fv ? ST_FRAME : ST_IDLE;
            end
`else
            ST_FRAME: begin
                if (frame_end) state_next = ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- counters and output ----------------
    logic        counter_clear;
    logic        is_trailer;
    logic [15:0] qv_cnt_reg, drop_cnt_reg;
    logic [15:0] qv_base, drop_base;
    logic [15:0] qv_cnt_next, drop_cnt_next;
    logic [16:0] drop_sum;
    logic [4:0]  drop_add;
    logic        capped;
    logic        emit;
    logic [31:0] q_reg, q_next, trailer_word;
    logic        qv_reg, qv_next;

    assign is_trailer = (state_reg == ST_TRAILER);

`ifdef CORNER_TRAILER_EN
    assign counter_clear = is_trailer;
`else
    assign counter_clear = frame_start;
`endif

    assign trailer_word = {TRAILER_MARK, CAM_ADDR, sat12(drop_cnt_reg), qv_cnt_reg};

    // Clear first, then add this cycle's events on top of the cleared value.
    always_comb begin
        qv_base       = counter_clear ? 16'h0 : qv_cnt_reg;
        drop_base     = counter_clear ? 16'h0 : drop_cnt_reg;
        capped        = (qv_base == 16'(MAX_QV));
        emit          = pop & ~capped;
        drop_add      = popcount16(16'(lane_drop)) + 5'(pop & capped);
        drop_sum      = {1'b0, drop_base} + 17'(drop_add);
        drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        qv_cnt_next   = qv_base + 16'(emit);
        qv_next       = is_trailer | emit;
        q_next        = q_reg;
        if (is_trailer) begin
            q_next = trailer_word;
        end else if (emit) begin
            q_next = lane_data[grant_idx];
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            q_reg        <= '0;
            qv_reg       <= 1'b0;
            qv_cnt_reg   <= '0;
            drop_cnt_reg <= '0;
        end else begin
            q_reg        <= q_next;
            qv_reg       <= qv_next;
            qv_cnt_reg   <= qv_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign q        = q_reg;
    assign qv       = qv_reg;
    assign qv_cnt   = qv_cnt_reg;
    assign drop_cnt = drop_cnt_reg;
    assign busy     = ~all_idle | (state_reg != ST_IDLE);

endmodule
